// File: rtl/sound_pkg.sv
// ---------------------------------------------------------------------------
// sound_pkg
// Shared types and constants for the sound scheduler:
//   note_t        - one melody note: divider value (0 = rest) and duration
//                   in ticks (0 = end-of-melody marker)
//   state_t       - scheduler FSM states
//   NUM_MELODIES, NOTES_PER_MELODY and derived index widths
//   melody_note() - constant melody table lookup
// ---------------------------------------------------------------------------
package sound_pkg;

   localparam int NUM_MELODIES     = 4;
   localparam int NOTES_PER_MELODY = 8;
   localparam int MEL_W            = $clog2(NUM_MELODIES);
   localparam int NOTE_W           = $clog2(NOTES_PER_MELODY);

   typedef struct packed {
      logic [15:0] div;
      logic [3:0]  dur;
   } note_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PLAY,
      ST_GAP
   } state_t;

   // Melody table. Entries not listed read as {0, 0}, which terminates the
   // melody. Melody 1 fills all eight slots and ends on the last note.
   function automatic note_t melody_note(input logic [MEL_W-1:0]  mel,
                                         input logic [NOTE_W-1:0] idx);
      note_t n;
      n = '{div: 16'd0, dur: 4'd0};
      case ({mel, idx})
         {2'd0, 3'd0}: n = '{div: 16'd3000, dur: 4'd1};
         {2'd0, 3'd1}: n = '{div: 16'd2000, dur: 4'd1};
         {2'd1, 3'd0}: n = '{div: 16'd1100, dur: 4'd1};
         {2'd1, 3'd1}: n = '{div: 16'd1200, dur: 4'd1};
         {2'd1, 3'd2}: n = '{div: 16'd0,    dur: 4'd1};
         {2'd1, 3'd3}: n = '{div: 16'd1400, dur: 4'd1};
         {2'd1, 3'd4}: n = '{div: 16'd1500, dur: 4'd1};
         {2'd1, 3'd5}: n = '{div: 16'd1600, dur: 4'd1};
         {2'd1, 3'd6}: n = '{div: 16'd1700, dur: 4'd1};
         {2'd1, 3'd7}: n = '{div: 16'd1800, dur: 4'd2};
         {2'd2, 3'd0}: n = '{div: 16'd1000, dur: 4'd2};
         {2'd2, 3'd1}: n = '{div: 16'd0,    dur: 4'd1};
         {2'd2, 3'd2}: n = '{div: 16'd500,  dur: 4'd1};
         {2'd3, 3'd0}: n = '{div: 16'd4000, dur: 4'd3};
         {2'd3, 3'd1}: n = '{div: 16'd4500, dur: 4'd1};
         default: ;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/melody_rom.sv
// ---------------------------------------------------------------------------
// melody_rom
// Combinational lookup of one note from the constant melody table.
// Ports:
//   mel_idx_i   melody index
//   note_idx_i  note position within the melody
//   note_o      {div, dur} of the addressed note
// ---------------------------------------------------------------------------
module melody_rom
   import sound_pkg::*;
(
   input  logic [MEL_W-1:0]  mel_idx_i,
   input  logic [NOTE_W-1:0] note_idx_i,
   output note_t             note_o
);

   assign note_o = melody_note(mel_idx_i, note_idx_i);

endmodule

// File: rtl/sound_scheduler.sv
// ---------------------------------------------------------------------------
// sound_scheduler
// Arbitrates melody requests and a button tone onto one speaker output.
// Requests are latched in a pending register; the lowest pending index wins
// when idle. Each note plays for dur*TICK_CYCLES cycles followed by
// GAP_TICKS*TICK_CYCLES silent cycles.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   req        melody request pulses, req[0] highest priority
//   btn_tone   button tone level, honoured only when idle with nothing pending
//   play       speaker enable (registered)
//   frequency  speaker divider value (registered)
//   grant      one-hot melody being played, 0 when none (registered)
//   busy       high whenever the FSM is not idle
//   done       one-cycle pulse when a melody ends or is aborted (registered)
// Build option:
//   SOUND_PREEMPT_EN  when defined, a strictly higher-priority pending request
//                     aborts the melody during PLAY or GAP.
// ---------------------------------------------------------------------------
module sound_scheduler
   import sound_pkg::*;
#(
   parameter int TICK_CYCLES = 2_500_000,
   parameter int GAP_TICKS   = 1,
   parameter int BTN_DIV     = 6250
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic        btn_tone,
   output logic        play,
   output logic [15:0] frequency,
   output logic [3:0]  grant,
   output logic        busy,
   output logic        done
);

   // Counter must hold the longest note (15 ticks) and the gap without wrap.
   localparam int MAX_TICKS = (GAP_TICKS > 15) ? GAP_TICKS : 15;
   localparam int CNT_W     = $clog2(MAX_TICKS * TICK_CYCLES + 1);

   localparam logic [CNT_W-1:0] TICK_C   = CNT_W'(TICK_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_TICKS * TICK_CYCLES - 1);
   localparam logic [15:0]      BTN_FREQ = 16'(BTN_DIV);
   localparam logic [NOTE_W-1:0] LAST_NOTE = NOTE_W'(NOTES_PER_MELODY - 1);

   state_t             state_q, state_d;
   logic [3:0]         pending_q, pending_d;
   logic [NOTE_W-1:0]  note_idx_q, note_idx_d;
   logic [CNT_W-1:0]   counter_q, counter_d;
   logic               play_q, play_d;
   logic [15:0]        freq_q, freq_d;
   logic [3:0]         grant_q, grant_d;
   logic               done_q, done_d;

   logic [3:0]         pending_clr;
   logic [3:0]         pick;
   logic [MEL_W-1:0]   mel_idx;
   logic               preempt;
   note_t              cur_note;

   // Isolate the lowest set bit: x & -x.
   assign pick = pending_q & (-pending_q);

   always_comb begin
      mel_idx = '0;
      for (int i = 0; i < NUM_MELODIES; i++) begin
         if (grant_q[i]) mel_idx = MEL_W'(i);
      end
   end

   melody_rom u_rom (
      .mel_idx_i  (mel_idx),
      .note_idx_i (note_idx_q),
      .note_o     (cur_note)
   );

`ifdef SOUND_PREEMPT_EN
   // grant is one-hot, so grant-1 masks every strictly higher-priority bit.
   assign preempt = |(pending_q & (grant_q - 4'd1));
`else
   assign preempt = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      pending_clr = '0;
      note_idx_d  = note_idx_q;
      counter_d   = counter_q;
      play_d      = play_q;
      freq_d      = freq_q;
      grant_d     = grant_q;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pending_q != '0) begin
               state_d     = ST_LOAD;
               pending_clr = pick;
               grant_d     = pick;
               note_idx_d  = '0;
               play_d      = 1'b0;
            end else begin
               play_d = btn_tone;
               if (btn_tone) freq_d = BTN_FREQ;
            end
         end

         ST_LOAD: begin
            if (cur_note.dur == 4'd0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               grant_d = '0;
               play_d  = 1'b0;
            end else begin
               state_d   = ST_PLAY;
               counter_d = CNT_W'(cur_note.dur) * TICK_C - CNT_ONE;
               play_d    = (cur_note.div != 16'd0);
               freq_d    = cur_note.div;
            end
         end

         ST_PLAY: begin
            if (preempt) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               grant_d = '0;
               play_d  = 1'b0;
            end else if (counter_q == '0) begin
               state_d   = ST_GAP;
               counter_d = GAP_LOAD;
               play_d    = 1'b0;
            end else begin
               counter_d = counter_q - CNT_ONE;
            end
         end

         ST_GAP: begin
            if (preempt) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               grant_d = '0;
               play_d  = 1'b0;
            end else if (counter_q == '0) begin
               if (note_idx_q == LAST_NOTE) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  grant_d = '0;
               end else begin
                  state_d    = ST_LOAD;
                  note_idx_d = note_idx_q + NOTE_W'(1);
               end
            end else begin
               counter_d = counter_q - CNT_ONE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // A new request wins over the clear of the same bit.
      pending_d = (pending_q & ~pending_clr) | req;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         note_idx_q <= '0;
         counter_q  <= '0;
         play_q     <= 1'b0;
         freq_q     <= '0;
         grant_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         note_idx_q <= note_idx_d;
         counter_q  <= counter_d;
         play_q     <= play_d;
         freq_q     <= freq_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
      end
   end

   assign play      = play_q;
   assign frequency = freq_q;
   assign grant     = grant_q;
   assign done      = done_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sound_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sound_scheduler
// Directed scenarios followed by random requests / button / reset traffic.
// The reference model expands a granted melody into a timeline of expected
// output frames (load, tone, gap, done) from the note table and timing rules.
// ---------------------------------------------------------------------------
module tb_sound_scheduler;

   localparam int TC  = 4;
   localparam int GAP = 1;
   localparam int BTN = 6250;

`ifdef SOUND_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic        btn_tone;
   logic        play;
   logic [15:0] frequency;
   logic [3:0]  grant;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   sound_scheduler #(
      .TICK_CYCLES (TC),
      .GAP_TICKS   (GAP),
      .BTN_DIV     (BTN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .btn_tone  (btn_tone),
      .play      (play),
      .frequency (frequency),
      .grant     (grant),
      .busy      (busy),
      .done      (done)
   );

   // Independent copy of the melody table (dur 0 ends a melody).
   int mdiv [4][8] = '{'{3000, 2000, 0, 0, 0, 0, 0, 0},
                       '{1100, 1200, 0, 1400, 1500, 1600, 1700, 1800},
                       '{1000, 0, 500, 0, 0, 0, 0, 0},
                       '{4000, 4500, 0, 0, 0, 0, 0, 0}};
   int mdur [4][8] = '{'{1, 1, 0, 0, 0, 0, 0, 0},
                       '{1, 1, 1, 1, 1, 1, 1, 2},
                       '{2, 1, 1, 0, 0, 0, 0, 0},
                       '{3, 1, 0, 0, 0, 0, 0, 0}};

   typedef enum logic [1:0] {K_IDLE, K_LOAD, K_TONE, K_GAP} kind_t;
   typedef struct packed {
      kind_t       kind;
      logic        play;
      logic [15:0] freq;
      logic [3:0]  grant;
      logic        done;
   } frame_t;

   frame_t      mq[$];
   frame_t      cur;
   logic [3:0]  pend;
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;

   function automatic frame_t mk(kind_t k, logic p, logic [15:0] f, logic [3:0] g, logic d);
      frame_t fr;
      fr.kind = k; fr.play = p; fr.freq = f; fr.grant = g; fr.done = d;
      return fr;
   endfunction

   // Expand melody m into its full output timeline, ending with the idle
   // cycle that carries the done pulse.
   function automatic void build(int m);
      logic [3:0] g;
      g = 4'(1 << m);
      for (int k = 0; k < 8; k++) begin
         mq.push_back(mk(K_LOAD, 1'b0, 16'd0, g, 1'b0));
         if (mdur[m][k] == 0) begin
            mq.push_back(mk(K_IDLE, 1'b0, 16'd0, 4'd0, 1'b1));
            return;
         end
         for (int t = 0; t < mdur[m][k] * TC; t++)
            mq.push_back(mk(K_TONE, mdiv[m][k] != 0, 16'(mdiv[m][k]), g, 1'b0));
         for (int t = 0; t < GAP * TC; t++)
            mq.push_back(mk(K_GAP, 1'b0, 16'd0, g, 1'b0));
      end
      mq.push_back(mk(K_IDLE, 1'b0, 16'd0, 4'd0, 1'b1));
   endfunction

   function automatic bit higher_pending(logic [3:0] p, logic [3:0] g);
      int gi_idx;
      gi_idx = 0;
      for (int i = 0; i < 4; i++) if (g[i]) gi_idx = i;
      for (int i = 0; i < gi_idx; i++) if (p[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_edge(input logic [3:0] r, input logic b, input logic rn);
      logic [3:0] clr;
      int sel;
      if (!rn) begin
         mq.delete();
         pend = '0;
         cur  = mk(K_IDLE, 1'b0, 16'd0, 4'd0, 1'b0);
         return;
      end
      clr = '0;
      if (cur.kind != K_IDLE) begin
         if (PREEMPT && (cur.kind == K_TONE || cur.kind == K_GAP) &&
             higher_pending(pend, cur.grant)) begin
            mq.delete();
            cur = mk(K_IDLE, 1'b0, 16'd0, 4'd0, 1'b1);
         end else begin
            cur = mq.pop_front();
         end
      end else begin
         sel = -1;
         for (int i = 3; i >= 0; i--) if (pend[i]) sel = i;
         if (sel >= 0) begin
            clr[sel] = 1'b1;
            build(sel);
            cur = mq.pop_front();
         end else begin
            cur = mk(K_IDLE, b, b ? 16'(BTN) : 16'd0, 4'd0, 1'b0);
         end
      end
      pend = (pend & ~clr) | r;
   endtask

   task automatic check();
      vectors++;
      assert (play === cur.play) else begin
         miscompares++;
         $error("FAIL play cyc=%0d got=%b exp=%b", cyc, play, cur.play);
      end
      assert (grant === cur.grant) else begin
         miscompares++;
         $error("FAIL grant cyc=%0d got=%b exp=%b", cyc, grant, cur.grant);
      end
      assert (done === cur.done) else begin
         miscompares++;
         $error("FAIL done cyc=%0d got=%b exp=%b", cyc, done, cur.done);
      end
      assert (busy === (cur.kind != K_IDLE)) else begin
         miscompares++;
         $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, cur.kind != K_IDLE);
      end
      if (cur.play) begin
         assert (frequency === cur.freq) else begin
            miscompares++;
            $error("FAIL frequency cyc=%0d got=%0d exp=%0d", cyc, frequency, cur.freq);
         end
      end
   endtask

   task automatic step(input logic [3:0] r, input logic b, input logic rn);
      req = r; btn_tone = b; rst_n = rn;
      @(posedge clk);
      model_edge(r, b, rn);
      cyc++;
      #1;
      check();
      if (cur.done || r != 4'd0 || !rn)
         $display("cyc=%0d rst_n=%b req=%b btn=%b -> play=%b freq=%0d grant=%b busy=%b done=%b",
                  cyc, rn, r, b, play, frequency, grant, busy, done);
   endtask

   task automatic run(input int n, input logic b);
      for (int i = 0; i < n; i++) step(4'd0, b, 1'b1);
   endtask

   initial begin
      logic btn_lvl;
      logic [3:0] r;
      logic rn;
      cur  = mk(K_IDLE, 1'b0, 16'd0, 4'd0, 1'b0);
      pend = '0;
      req = '0; btn_tone = 1'b0; rst_n = 1'b0;

      // Reset state
      for (int i = 0; i < 3; i++) step(4'd0, 1'b0, 1'b0);
      assert (frequency === 16'd0) else begin
         miscompares++;
         $error("FAIL reset_freq got=%0d exp=0", frequency);
      end

      // Single melody 2 with a rest
      step(4'b0100, 1'b0, 1'b1);
      run(45, 1'b0);

      // Two simultaneous requests: 1 then 3
      step(4'b1010, 1'b0, 1'b1);
      run(120, 1'b0);

      // Button tone, then replaced by melody 0; button held through melody
      run(5, 1'b1);
      step(4'b0001, 1'b1, 1'b1);
      run(30, 1'b1);
      run(3, 1'b0);

      // Higher-priority request during melody 2 (preempts when enabled)
      step(4'b0100, 1'b0, 1'b1);
      run(10, 1'b0);
      step(4'b0001, 1'b0, 1'b1);
      run(70, 1'b0);

      // Re-request of the playing melody is replayed afterwards
      step(4'b1000, 1'b0, 1'b1);
      run(6, 1'b0);
      step(4'b1000, 1'b0, 1'b1);
      run(70, 1'b0);

      // Reset mid-note with pending and coincident requests discarded
      step(4'b0010, 1'b0, 1'b1);
      run(4, 1'b0);
      step(4'b0100, 1'b0, 1'b1);
      run(2, 1'b0);
      step(4'b1000, 1'b0, 1'b0);
      run(20, 1'b0);

      // Random traffic
      btn_lvl = 1'b0;
      for (int n = 0; n < 800; n++) begin
         r = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         if ($urandom_range(0, 9) == 0) btn_lvl = ~btn_lvl;
         rn = ($urandom_range(0, 299) != 0);
         step(r, btn_lvl, rn);
      end
      run(150, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sound_scheduler.md
SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 Parameter TICK_CYCLES, default 2_500_000, clk cycles per duration tick (50 ms at 50 MHz).
REQ-002 Parameter GAP_TICKS, default 1, silent ticks inserted after every melody note.
REQ-003 Parameter BTN_DIV, default 6250, frequency value driven for the button tone.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  4  melody request pulses; req[0] highest priority.
REQ-007 btn_tone  input  1  level; button-press tone request (lowest priority).
REQ-008 play  output  1  Speaker enable.
REQ-009 frequency  output  16  Speaker divider value.
REQ-010 grant  output  4  one-hot index of the melody playing; 0 when none.
REQ-011 busy  output  1  high in any state except IDLE.
REQ-012 done  output  1  one-cycle pulse when a melody completes or is aborted.

Function
REQ-013 Any req[i] high in cycle n sets pending[i] at edge n+1; if set and clear of the same bit coincide, set wins.
REQ-014 FSM states: IDLE, LOAD, PLAY, GAP.
REQ-015 IDLE with pending != 0 -> LOAD; selects the lowest set index i, clears pending[i], sets grant = 1<<i, note_idx = 0.
REQ-016 IDLE with pending == 0 and btn_tone = 1 -> play = 1, frequency = BTN_DIV, same cycle as registered state; btn_tone = 0 -> play = 0.
REQ-017 LOAD reads note {div[15:0], dur[3:0]} at (grant index, note_idx); dur == 0 -> IDLE (end of melody, done pulse); otherwise -> PLAY with counter = dur*TICK_CYCLES - 1.
REQ-018 PLAY: play = (div != 0), frequency = div (div == 0 is a rest); counter decrements each cycle; at 0 -> GAP with counter = GAP_TICKS*TICK_CYCLES - 1.
REQ-019 GAP: play = 0, frequency holds; at counter 0: note_idx == 7 -> IDLE with done pulse, else note_idx+1 and -> LOAD.
REQ-020 Note durations are exact: play high for exactly dur*TICK_CYCLES cycles per note.
REQ-021 On return to IDLE: grant = 0 in the same cycle done = 1.
REQ-022 Request for the currently granted melody during playback is latched in pending and replayed afterwards.
REQ-023 btn_tone is ignored while busy.
REQ-024 Counter width sized for 15*TICK_CYCLES; no wrap permitted.

Reset
REQ-025 rst_n = 0 at a clk edge: state = IDLE, pending = 0, note_idx = 0, counter = 0, play = 0, frequency = 0, grant = 0, busy = 0, done = 0.
REQ-026 Reset mid-melody aborts it with no done pulse; requests seen during reset are discarded.

Configuration
REQ-027 Macro SOUND_PREEMPT_EN defined: in PLAY or GAP, a pending bit of strictly higher priority than grant aborts the melody at the next edge -> done pulse, then LOAD of the new melody one cycle later; the aborted melody is not re-queued.
REQ-028 Macro SOUND_PREEMPT_EN undefined: melodies always run to completion; higher-priority requests wait in pending.

Structure
REQ-029 Package sound_pkg holds: note struct type (div, dur), state enum, NUM_MELODIES = 4, NOTES_PER_MELODY = 8, melody ROM contents.
REQ-030 Sub-module melody_rom (combinational lookup from sound_pkg constants) is instantiated once; the FSM, pending latch and counters are in sound_scheduler.
REQ-031 Outputs play, frequency, grant, done are registered.

Verification (TICK_CYCLES = 4, GAP_TICKS = 1, test ROM: melody 2 = {(1000,2),(0,1),(500,1),(x,0)})
REQ-032 Pulse req[2] one cycle -> grant = 4'b0100; play high 8 cycles at 1000, low 4 gap, low 4 rest, low 4 gap, high 4 at 500, low 4 gap, then done pulse, grant = 0.
REQ-033 req = 4'b1010 same cycle -> melody 1 plays first, melody 3 starts immediately after done of melody 1.
REQ-034 btn_tone = 1 while idle -> play = 1, frequency = 6250; raise req[0] -> button tone replaced by melody 0 two cycles later; btn_tone ignored until done.
REQ-035 With SOUND_PREEMPT_EN: req[2] playing, pulse req[0] -> done pulse next cycle, grant = 4'b0001 one cycle later; without macro: melody 2 completes first.
REQ-036 rst_n = 0 mid-note for one cycle -> next cycle all outputs 0, pending cleared, no done pulse; a req pulse coincident with reset is not played.
